// File: rtl/switch_debounce3_pkg.sv
// Shared constants and FSM encoding for the three-way light switch front end.
package switch_debounce3_pkg;

    localparam int LIGHT_NSW        = 3;
    localparam int DEBOUNCE_DEFAULT = 4;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } deb_state_e;

endpackage

// File: rtl/switch_debounce3_cell.sv
// One switch channel: multi-flop synchroniser followed by a counter-based debouncer.
module debounce_cell
    import switch_debounce3_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int   SYNC_STAGES     = 2,
    parameter logic INIT_LEVEL      = 1'b0,
    parameter int   CNT_W           = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean,
    output logic pulse,
    output logic counting
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;

    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q, clean_d;
    logic             pulse_q, pulse_d;

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{INIT_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        pulse_d = 1'b0;
        unique case (state_q)
            ST_STABLE: begin
                cnt_d = '0;
                if (sync_out != clean_q) begin
                    state_d = ST_COUNT;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_COUNT: begin
                if (sync_out == clean_q) begin
                    // Bounce back to the old level clears the count entirely.
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                    clean_d = sync_out;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            clean_q <= INIT_LEVEL;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            pulse_q <= pulse_d;
        end
    end

    assign clean    = clean_q;
    assign pulse    = pulse_q;
    assign counting = (state_q == ST_COUNT);

endmodule

// File: rtl/switch_debounce3.sv
// Three-channel switch conditioner feeding x1..x3 of the three-way light logic.
module switch_debounce3
    import switch_debounce3_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int   SYNC_STAGES     = 2,
    parameter logic INIT_LEVEL      = 1'b0,
    parameter int   CNT_W           = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [LIGHT_NSW-1:0] sw_raw,
    output logic [LIGHT_NSW-1:0] sw_clean,
    output logic [LIGHT_NSW-1:0] toggle_pulse,
    output logic                 busy
);

    logic [LIGHT_NSW-1:0] counting;

    for (genvar i = 0; i < LIGHT_NSW; i++) begin : g_ch
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES),
            .INIT_LEVEL     (INIT_LEVEL),
            .CNT_W          (CNT_W)
        ) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .raw     (sw_raw[i]),
            .clean   (sw_clean[i]),
            .pulse   (toggle_pulse[i]),
            .counting(counting[i])
        );
    end

    // Each counting bit is decoded straight from a state flop, so busy has no path from sw_raw.
    assign busy = |counting;

endmodule

// File: tb/tb_switch_debounce3.sv
// Directed bench for switch_debounce3: reset, press, bounce, simultaneous, mid-count reset, threshold.
module tb_switch_debounce3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] sw_raw = 3'b000;
    logic [2:0] sw_clean;
    logic [2:0] toggle_pulse;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    switch_debounce3 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_raw      (sw_raw),
        .sw_clean    (sw_clean),
        .toggle_pulse(toggle_pulse),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a level and let it fully commit.
    task automatic settle(input logic [2:0] lvl);
        sw_raw = lvl;
        repeat (10) step();
        vectors++;
        if (sw_clean !== lvl) begin
            $display("FAIL settle: sw_clean=%b expected %b", sw_clean, lvl);
            miscompares++;
        end
    endtask

    // Step through edges E0..E0+last after a held change, checking latency profile.
    task automatic run_change(input string name, input logic [2:0] from_lvl, input logic [2:0] to_lvl, input int last);
        logic [2:0] exp_clean, exp_pulse;
        logic       exp_busy;
        for (int k = 0; k <= last; k++) begin
            step();
            exp_clean = (k >= 5) ? to_lvl : from_lvl;
            exp_pulse = (k == 5) ? (to_lvl ^ from_lvl) : 3'b000;
            exp_busy  = (k >= 2) && (k <= 4);
            vectors++;
            if (sw_clean !== exp_clean || toggle_pulse !== exp_pulse || busy !== exp_busy) begin
                $display("FAIL %s E0+%0d: clean=%b pulse=%b busy=%b expected clean=%b pulse=%b busy=%b",
                         name, k, sw_clean, toggle_pulse, busy, exp_clean, exp_pulse, exp_busy);
                miscompares++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        sw_raw = 3'b101;
        for (int k = 0; k < 3; k++) begin
            step();
            vectors++;
            if (sw_clean !== 3'b000 || toggle_pulse !== 3'b000 || busy !== 1'b0) begin
                $display("FAIL reset_hold: clean=%b pulse=%b busy=%b expected 000/000/0",
                         sw_clean, toggle_pulse, busy);
                miscompares++;
            end
        end
        #2 rst_n = 1'b1;
        run_change("reset_release", 3'b000, 3'b101, 6);
        settle(3'b000);
    endtask

    task automatic test_clean_press();
        sw_raw = 3'b001;
        run_change("clean_press", 3'b000, 3'b001, 6);
        settle(3'b000);
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 6; k++) begin
            sw_raw = {1'b0, k[0], 1'b0};
            step();
            vectors++;
            if (sw_clean !== 3'b000 || toggle_pulse !== 3'b000) begin
                $display("FAIL bounce cycle %0d: clean=%b pulse=%b expected 000/000",
                         k, sw_clean, toggle_pulse);
                miscompares++;
            end
        end
        sw_raw = 3'b000;
        for (int k = 0; k < 5; k++) begin
            step();
            vectors++;
            if (sw_clean !== 3'b000 || toggle_pulse !== 3'b000) begin
                $display("FAIL bounce_tail %0d: clean=%b pulse=%b expected 000/000",
                         k, sw_clean, toggle_pulse);
                miscompares++;
            end
        end
        vectors++;
        if (busy !== 1'b0) begin
            $display("FAIL bounce_busy: busy=%b expected 0", busy);
            miscompares++;
        end
    endtask

    task automatic test_simultaneous();
        sw_raw = 3'b111;
        run_change("simultaneous", 3'b000, 3'b111, 6);
        settle(3'b000);
    endtask

    task automatic test_reset_mid_count();
        sw_raw = 3'b010;
        for (int k = 0; k <= 3; k++) step();
        vectors++;
        if (busy !== 1'b1) begin
            $display("FAIL midcount_busy: busy=%b expected 1", busy);
            miscompares++;
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (sw_clean !== 3'b000 || toggle_pulse !== 3'b000 || busy !== 1'b0) begin
            $display("FAIL midcount_async: clean=%b pulse=%b busy=%b expected 000/000/0",
                     sw_clean, toggle_pulse, busy);
            miscompares++;
        end
        step();
        step();
        #2 rst_n = 1'b1;
        run_change("midcount_requal", 3'b000, 3'b010, 6);
        settle(3'b000);
    endtask

    task automatic test_threshold();
        int pulses;
        // Three-sample glitch on x1 must be rejected.
        sw_raw = 3'b001;
        for (int k = 0; k <= 2; k++) step();
        sw_raw = 3'b000;
        for (int k = 3; k <= 8; k++) begin
            step();
            vectors++;
            if (sw_clean !== 3'b000 || toggle_pulse !== 3'b000) begin
                $display("FAIL glitch3 E0+%0d: clean=%b pulse=%b expected 000/000",
                         k, sw_clean, toggle_pulse);
                miscompares++;
            end
        end
        // Four-sample level is accepted with exactly one pulse.
        pulses = 0;
        sw_raw = 3'b001;
        for (int k = 0; k <= 3; k++) begin
            step();
            if (toggle_pulse[0]) pulses++;
        end
        sw_raw = 3'b000;
        for (int k = 4; k <= 8; k++) begin
            step();
            if (toggle_pulse[0]) pulses++;
            vectors++;
            if (sw_clean !== ((k >= 5) ? 3'b001 : 3'b000)) begin
                $display("FAIL hold4 E0+%0d: clean=%b expected %b",
                         k, sw_clean, (k >= 5) ? 3'b001 : 3'b000);
                miscompares++;
            end
        end
        vectors++;
        if (pulses != 1) begin
            $display("FAIL hold4_pulses: got %0d expected 1", pulses);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid_count();
        test_threshold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
